ibus_arbiter: RTL and testbench

- Two-master arbiter for the systolic array's 16-bit indirect bus (ibus), which today has a single owner.
- Master 0 is the CPU's ibus port; master 1 is a second engine (UART loader or matrix DMA).
- Grants the bus with round-robin priority and bounded bursts.
- Tags each read with its issuing master and returns the read data to that master after the fixed slave latency.

---
 rtl/ibus_pkg.sv | 18 +
 rtl/ibus_rd_tag_pipe.sv | 45 ++++
 rtl/ibus_arbiter.sv | 150 +++++++++++++++
 tb/tb_ibus_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibus_pkg.sv
// Shared definitions for the two-master ibus arbiter: bus widths and
// ownership state encoding.
package ibus_pkg;

  localparam int IBUS_AW = 18;
  localparam int IBUS_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  function automatic arb_state_e own_state(input logic id);
    return id ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/ibus_rd_tag_pipe.sv
// RD_LAT-deep shift register of {valid, master id}; the tail entry lines up
// with the slave's read data for the read issued RD_LAT cycles earlier.
module ibus_rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic id,
  output logic tail_valid,
  output logic tail_id
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] valid_d;
  logic [RD_LAT-1:0] id_q;
  logic [RD_LAT-1:0] id_d;

  // shift every cycle; an idle cycle inserts an invalid entry
  always_comb begin
    valid_d    = '0;
    id_d       = '0;
    valid_d[0] = push;
    id_d[0]    = push & id;
    for (int i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      id_d[i]    = id_q[i-1];
    end
  end

  // tag storage; reset drops every read in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign tail_valid = valid_q[RD_LAT-1];
  assign tail_id    = id_q[RD_LAT-1];

endmodule

// File: rtl/ibus_arbiter.sv
// Round-robin, burst-bounded arbiter letting two masters share the ibus;
// read data is routed back to the issuing master after the slave latency.
module ibus_arbiter
  import ibus_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic [IBUS_AW-1:0] m0_adr,
  input  logic [IBUS_DW-1:0] m0_wdata,
  output logic               m0_gnt,
  output logic               m0_rvalid,
  output logic [IBUS_DW-1:0] m0_rdata,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic [IBUS_AW-1:0] m1_adr,
  input  logic [IBUS_DW-1:0] m1_wdata,
  output logic               m1_gnt,
  output logic               m1_rvalid,
  output logic [IBUS_DW-1:0] m1_rdata,
  output logic               ibus_ren,
  output logic [IBUS_AW-1:0] ibus_radr,
  input  logic [IBUS_DW-1:0] ibus_rdata,
  output logic               ibus_wen,
  output logic [IBUS_AW-1:0] ibus_wadr,
  output logic [IBUS_DW-1:0] ibus_wdata
);

  localparam logic [5:0] LAST_BEAT = 6'(MAX_BURST - 1);

  arb_state_e state_q, state_d;
  logic       rr_q, rr_d;
  logic [5:0] beat_cnt_q, beat_cnt_d;

  logic own_id_s;
  logic own_req_s;
  logic oth_req_s;
  logic rd_push_s;
  logic tail_valid_s;
  logic tail_id_s;

  assign own_id_s  = (state_q == OWN1);
  assign own_req_s = own_id_s ? m1_req : m0_req;
  assign oth_req_s = own_id_s ? m0_req : m1_req;

  // next-state, round-robin pointer and burst counter
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        beat_cnt_d = 6'd0;
        if (m0_req && m1_req) begin
          state_d = own_state(rr_q);
        end else if (m0_req) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (!own_req_s) begin
          // owner let go: hand straight over if the other side is waiting
          state_d    = oth_req_s ? own_state(~own_id_s) : IDLE;
          rr_d       = ~own_id_s;
          beat_cnt_d = 6'd0;
        end else if ((beat_cnt_q == LAST_BEAT) && oth_req_s) begin
          state_d    = own_state(~own_id_s);
          rr_d       = ~own_id_s;
          beat_cnt_d = 6'd0;
        end else if (beat_cnt_q != LAST_BEAT) begin
          beat_cnt_d = beat_cnt_q + 6'd1;
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = 6'd0;
      end
    endcase
  end

  // arbitration state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      beat_cnt_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign m0_gnt = (state_q == OWN0) & m0_req;
  assign m1_gnt = (state_q == OWN1) & m1_req;

  // bus mux: everything reads zero when no beat is granted
  always_comb begin
    ibus_ren   = 1'b0;
    ibus_wen   = 1'b0;
    ibus_radr  = '0;
    ibus_wadr  = '0;
    ibus_wdata = '0;
    if (m0_gnt) begin
      ibus_ren   = ~m0_we;
      ibus_wen   = m0_we;
      ibus_radr  = m0_adr;
      ibus_wadr  = m0_adr;
      ibus_wdata = m0_wdata;
    end else if (m1_gnt) begin
      ibus_ren   = ~m1_we;
      ibus_wen   = m1_we;
      ibus_radr  = m1_adr;
      ibus_wadr  = m1_adr;
      ibus_wdata = m1_wdata;
    end else begin
      ibus_ren   = 1'b0;
      ibus_wen   = 1'b0;
    end
  end

  assign rd_push_s = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);

  ibus_rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .push       (rd_push_s),
    .id         (m1_gnt),
    .tail_valid (tail_valid_s),
    .tail_id    (tail_id_s)
  );

  assign m0_rvalid = tail_valid_s & ~tail_id_s;
  assign m1_rvalid = tail_valid_s & tail_id_s;
  assign m0_rdata  = m0_rvalid ? ibus_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ibus_rdata : '0;

endmodule

// File: tb/tb_ibus_arbiter.sv
// Scoreboard bench for ibus_arbiter: three instances (RD_LAT = 1, 2, 3) share
// the same master stimulus; each has its own slave model and monitor.
module tb_ibus_arbiter;

  localparam int ND = 3;

  typedef struct packed {
    logic        we;
    logic [17:0] adr;
    logic [15:0] wd;
    logic [7:0]  dly;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [17:0] m0_adr = '0, m1_adr = '0;
  logic [15:0] m0_wdata = '0, m1_wdata = '0;

  logic [ND-1:0]        m0_gnt_w, m1_gnt_w, m0_rvalid_w, m1_rvalid_w, ren_w, wen_w;
  logic [ND-1:0][15:0]  m0_rdata_w, m1_rdata_w, wdata_w, ibus_rdata_w;
  logic [ND-1:0][17:0]  radr_w, wadr_w;

  int cyc = 0;
  int t0 = 0;
  int n_chk = 0;
  int n_fail = 0;

  item_t q0[$];
  item_t q1[$];

  // expected beats and read returns, shared by all instances
  logic        b_m [128];
  logic        b_we [128];
  logic [17:0] b_adr [128];
  logic [15:0] b_wd [128];
  int          b_cyc [128];
  int          bn = 0;
  logic        r_m [32];
  logic [15:0] r_d [32];
  int          rn = 0;

  int due [ND][64];
  int dr [ND] = '{0, 0, 0};
  int dw [ND] = '{0, 0, 0};
  int bi [ND] = '{0, 0, 0};
  int ri [ND] = '{0, 0, 0};

  logic [ND-1:0][3:0]       sv_r = '0;
  logic [ND-1:0][3:0][17:0] sa_r = '0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    ibus_arbiter #(.RD_LAT(g + 1), .MAX_BURST(8)) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt_w[g]), .m0_rvalid(m0_rvalid_w[g]), .m0_rdata(m0_rdata_w[g]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt_w[g]), .m1_rvalid(m1_rvalid_w[g]), .m1_rdata(m1_rdata_w[g]),
      .ibus_ren(ren_w[g]), .ibus_radr(radr_w[g]), .ibus_rdata(ibus_rdata_w[g]),
      .ibus_wen(wen_w[g]), .ibus_wadr(wadr_w[g]), .ibus_wdata(wdata_w[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] slave_val(input logic [17:0] a);
    return a[15:0] ^ 16'hBEFF;
  endfunction

  // slave for instance d returns data d+1 cycles after the read strobe
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      sv_r[d] <= {sv_r[d][2:0], ren_w[d]};
      sa_r[d] <= {sa_r[d][2:0], radr_w[d]};
    end
  end

  always_comb begin
    ibus_rdata_w = '0;
    for (int d = 0; d < ND; d++) begin
      ibus_rdata_w[d] = sv_r[d][d] ? slave_val(sa_r[d][d]) : 16'hDEAD;
    end
  end

  task automatic check(input string name, input int d, input logic [95:0] act,
                       input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s rd_lat=%0d cyc=%0d: got %h expected %h", name, d + 1, cyc, act, exp);
    end
  endtask

  function automatic logic [95:0] all_out(input int d);
    return 96'({m0_gnt_w[d], m1_gnt_w[d], m0_rvalid_w[d], m1_rvalid_w[d], ren_w[d], wen_w[d],
                m0_rdata_w[d], m1_rdata_w[d], radr_w[d], wadr_w[d], wdata_w[d]});
  endfunction

  // monitor: compares each instance against the expected beats and returns
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        check("rst_outputs", d, all_out(d), 96'd0);
        dr[d] = dw[d];
        ri[d] = rn;
      end else begin
        if (bi[d] < bn && b_cyc[bi[d]] == cyc) begin
          check("gnt", d, 96'({m1_gnt_w[d], m0_gnt_w[d]}), 96'(b_m[bi[d]] ? 2'b10 : 2'b01));
          check("bus", d, 96'({wen_w[d], ren_w[d], wadr_w[d], radr_w[d], wdata_w[d]}),
                96'({b_we[bi[d]], ~b_we[bi[d]], b_adr[bi[d]], b_adr[bi[d]], b_wd[bi[d]]}));
          bi[d]++;
        end else begin
          check("idle_bus", d, 96'({m1_gnt_w[d], m0_gnt_w[d], wen_w[d], ren_w[d],
                                    wadr_w[d], radr_w[d], wdata_w[d]}), 96'd0);
        end
        if (dr[d] < dw[d] && due[d][dr[d]] == cyc) begin
          check("rd_pending", d, 96'(ri[d] < rn), 96'd1);
          if (ri[d] < rn) begin
            check("rvalid", d, 96'({m1_rvalid_w[d], m0_rvalid_w[d]}),
                  96'(r_m[ri[d]] ? 2'b10 : 2'b01));
            check("rdata", d, 96'({m1_rdata_w[d], m0_rdata_w[d]}),
                  96'(r_m[ri[d]] ? {r_d[ri[d]], 16'h0000} : {16'h0000, r_d[ri[d]]}));
            ri[d]++;
          end
          dr[d]++;
        end else begin
          check("no_rvalid", d, 96'({m1_rvalid_w[d], m0_rvalid_w[d],
                                     m1_rdata_w[d], m0_rdata_w[d]}), 96'd0);
        end
        if (ren_w[d]) begin
          due[d][dw[d]] = cyc + d + 1;
          dw[d]++;
        end
      end
    end
  end

  // queue one master beat with its expected grant cycle (t0 + off)
  task automatic add(input logic m, input logic we, input logic [17:0] adr,
                     input logic [15:0] wd, input int dly, input int off);
    item_t it;
    it.we  = we;
    it.adr = adr;
    it.wd  = wd;
    it.dly = 8'(dly);
    if (m) q1.push_back(it);
    else   q0.push_back(it);
    b_m[bn]   = m;
    b_we[bn]  = we;
    b_adr[bn] = adr;
    b_wd[bn]  = wd;
    b_cyc[bn] = t0 + off;
    bn++;
    if (!we) begin
      r_m[rn] = m;
      r_d[rn] = slave_val(adr);
      rn++;
    end
  endtask

  task automatic apply_heads();
    if (q0.size() != 0 && cyc >= t0 + int'(q0[0].dly)) begin
      m0_req = 1'b1; m0_we = q0[0].we; m0_adr = q0[0].adr; m0_wdata = q0[0].wd;
    end else begin
      m0_req = 1'b0; m0_we = 1'b0; m0_adr = 18'h0; m0_wdata = 16'h0;
    end
    if (q1.size() != 0 && cyc >= t0 + int'(q1[0].dly)) begin
      m1_req = 1'b1; m1_we = q1[0].we; m1_adr = q1[0].adr; m1_wdata = q1[0].wd;
    end else begin
      m1_req = 1'b0; m1_we = 1'b0; m1_adr = 18'h0; m1_wdata = 16'h0;
    end
  endtask

  // drive both masters until their queues empty, popping on each grant
  task automatic run(input int budget, input bit drain);
    int n;
    logic g0, g1;
    n = 0;
    apply_heads();
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(negedge clk);
      g0 = m0_gnt_w[0];
      g1 = m1_gnt_w[0];
      @(posedge clk);
      #1;
      if (g0 && q0.size() != 0) void'(q0.pop_front());
      if (g1 && q1.size() != 0) void'(q1.pop_front());
      apply_heads();
      n++;
    end
    check("run_budget", 0, 96'(n >= budget), 96'd0);
    if (drain) begin
      repeat (6) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // both masters stream writes: 8 beats m0, 8 beats m1, then m0 again
    t0 = cyc;
    for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 18'h00100 + 18'(i), 16'hA000 + 16'(i), 0, 1 + i);
    for (int i = 0; i < 8; i++) add(1'b1, 1'b1, 18'h00200 + 18'(i), 16'hB000 + 16'(i), 0, 9 + i);
    for (int i = 8; i < 16; i++) add(1'b0, 1'b1, 18'h00100 + 18'(i), 16'hA000 + 16'(i), 0, 9 + i);
    run(60, 1'b1);

    // single read by m0 returning 0xBEEF
    t0 = cyc;
    add(1'b0, 1'b0, 18'h00010, 16'h0000, 0, 1);
    run(20, 1'b1);

    // lone m1 burst of 20 writes, never throttled
    t0 = cyc;
    for (int i = 0; i < 20; i++) add(1'b1, 1'b1, 18'h30000 + 18'(i), 16'hC000 + 16'(i), 0, 1 + i);
    run(60, 1'b1);

    // interleaved reads m0 / m1 / m0
    t0 = cyc;
    add(1'b0, 1'b0, 18'h00020, 16'h0000, 0, 1);
    add(1'b1, 1'b0, 18'h3FFFF, 16'h0000, 0, 3);
    add(1'b0, 1'b0, 18'h00031, 16'h0000, 3, 5);
    run(30, 1'b1);

    // back-to-back reads
    t0 = cyc;
    for (int i = 0; i < 4; i++) add(1'b0, 1'b0, 18'h00100 + 18'(i), 16'h0000, 0, 1 + i);
    run(30, 1'b1);

    // m0 drops after 3 beats; m1 takes over; rr then favours m0
    t0 = cyc;
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 18'h00400 + 18'(i), 16'hD000 + 16'(i), 0, 1 + i);
    add(1'b1, 1'b1, 18'h00500, 16'hE000, 1, 5);
    add(1'b1, 1'b1, 18'h00501, 16'hE001, 1, 6);
    add(1'b0, 1'b1, 18'h00403, 16'hD003, 8, 9);
    add(1'b1, 1'b1, 18'h00502, 16'hE002, 8, 11);
    run(40, 1'b1);

    // two reads in flight, then reset
    t0 = cyc;
    add(1'b0, 1'b0, 18'h00050, 16'h0000, 0, 1);
    add(1'b0, 1'b0, 18'h00051, 16'h0000, 0, 2);
    run(20, 1'b0);
    m0_req = 1'b1; m0_we = 1'b0; m0_adr = 18'h00052;
    m1_req = 1'b1; m1_we = 1'b1; m1_adr = 18'h00053;
    rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) check("rst_immediate", d, all_out(d), 96'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // first requests after reset: m0 (rr = 0) then m1 without bubble
    t0 = cyc;
    add(1'b0, 1'b1, 18'h00600, 16'hF000, 0, 1);
    add(1'b1, 1'b1, 18'h00700, 16'hF100, 0, 3);
    run(20, 1'b1);

    for (int d = 0; d < ND; d++) begin
      check("beats_done", d, 96'(bi[d]), 96'(bn));
      check("reads_done", d, 96'(ri[d]), 96'(rn));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
